mult_share_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one unsigned shift-add (left-shift) multiplier datapath between N_REQ requesters.
- Owns the multiplier's control: request acceptance, operand capture, step counting, result return and completion signalling.
- Sits between client blocks issuing multiply requests and the shared multiplier; gives a fixed-latency, handshaked multiply service.

---
 rtl/mult_share_arb_pkg.sv | 17 +
 rtl/shift_add_dp.sv | 57 +++++
 rtl/mult_share_arb.sv | 114 +++++++++++
 tb/tb_mult_share_arb.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_share_arb_pkg.sv
// Shared constants and FSM encoding for the shared shift-add multiplier arbiter.
package mult_arb_pkg;

  // Default sizing of the arbiter and datapath.
  localparam int DEF_N_REQ = 2;
  localparam int DEF_WIDTH = 6;

  // FSM encoding: one bit is enough for two states.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Index width that never collapses to zero bits (a single-entry range still needs one bit).
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shift_add_dp.sv
// Unsigned left-shift multiplier datapath. One partial product per step;
// the sequencer decides when to load and when to step.
import mult_arb_pkg::*;

module shift_add_dp #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  // Accumulator value including the partial product of the current step,
  // so the sequencer can latch the final product on the last step edge.
  output logic [2*WIDTH-1:0]   acc,
  output logic                 last
);

  localparam int CW = idx_w(WIDTH);

  logic [WIDTH-1:0]   a_reg;
  logic [2*WIDTH-1:0] b_shift;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      count;

  // Add the shifted multiplicand when the current multiplier bit is set.
  // Max product (2^W-1)^2 fits in 2W bits, so no carry-out is lost.
  always_comb begin
    acc = acc_q;
    if (a_reg[count]) begin
      acc = acc_q + b_shift;
    end
  end

  assign last = (count == CW'(WIDTH - 1));

  // Operand capture on load, one shift-add step per step pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg   <= '0;
      b_shift <= '0;
      acc_q   <= '0;
      count   <= '0;
    end else if (load) begin
      a_reg   <= a;
      b_shift <= {{WIDTH{1'b0}}, b};
      acc_q   <= '0;
      count   <= '0;
    end else if (step) begin
      acc_q   <= acc;
      b_shift <= b_shift << 1;
      count   <= count + CW'(1);
    end
  end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter and sequencer sharing one shift-add multiplier
// between N_REQ requesters. Fixed latency: grant edge, WIDTH step edges,
// done pulse in the cycle after the last step.
//
// Handshake: a requester holds req high with stable operands until it sees
// its gnt bit (one-cycle pulse, operands captured on that edge) and must drop
// req during the gnt cycle; done is a one-cycle pulse to the owner with
// product valid, and product holds until the next done.
import mult_arb_pkg::*;

module mult_share_arb #(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*WIDTH-1:0]       a_in,
  input  logic [N_REQ*WIDTH-1:0]       b_in,
  output logic [N_REQ-1:0]             gnt,
  output logic                         busy,
  output logic [idx_w(N_REQ)-1:0]      owner,
  output logic [N_REQ-1:0]             done,
  output logic [2*WIDTH-1:0]           product,
  output logic [0:0]                   dbg_state
);

  localparam int OW = idx_w(N_REQ);

  logic [0:0]         state;
  logic [OW-1:0]      ptr;
  logic [OW-1:0]      winner;
  logic               found;
  logic               load;
  logic               step;
  logic [WIDTH-1:0]   win_a;
  logic [WIDTH-1:0]   win_b;
  logic [2*WIDTH-1:0] dp_acc;
  logic               dp_last;
  int                 cand;

  assign dbg_state = state;

  // Round-robin pick: search from pointer + 1 with wrap-around.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (!found && req[cand[OW-1:0]]) begin
        found  = 1'b1;
        winner = cand[OW-1:0];
      end
    end
  end

  assign load  = (state == ST_IDLE) && found;
  assign step  = (state == ST_RUN);
  assign win_a = a_in[int'(winner)*WIDTH +: WIDTH];
  assign win_b = b_in[int'(winner)*WIDTH +: WIDTH];

  shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .a    (win_a),
    .b    (win_b),
    .acc  (dp_acc),
    .last (dp_last)
  );

  // Sequencer FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      done    <= '0;
      busy    <= 1'b0;
      product <= '0;
      owner   <= '0;
      // Pointing at the last requester makes requester 0 the first candidate.
      ptr     <= OW'(N_REQ - 1);
    end else begin
      gnt  <= '0;
      done <= '0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            gnt   <= N_REQ'(1) << winner;
            owner <= winner;
            ptr   <= winner;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (dp_last) begin
            product <= dp_acc;
            done    <= N_REQ'(1) << owner;
            busy    <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb: single ops, zero operands, round-robin
// ordering, reset during a run and operand isolation after grant.
module tb_mult_share_arb;
  import mult_arb_pkg::*;

  localparam int N_REQ = 2;
  localparam int WIDTH = 6;
  localparam int OW    = idx_w(N_REQ);

  logic                   clk;
  logic                   rst;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_in;
  logic [N_REQ*WIDTH-1:0] b_in;
  logic [N_REQ-1:0]       gnt;
  logic                   busy;
  logic [OW-1:0]          owner;
  logic [N_REQ-1:0]       done;
  logic [2*WIDTH-1:0]     product;
  logic [0:0]             dbg_state;

  int n_cmp;
  int n_err;
  int gnt_multi;
  int gnt_in_run;
  logic busy_prev;

  mult_share_arb #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .busy      (busy),
    .owner     (owner),
    .done      (done),
    .product   (product),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Grant protocol watch: never two grant bits, never a grant after a busy cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if ((gnt & (gnt - 1'b1)) != '0) gnt_multi++;
      if (gnt != '0 && busy_prev) gnt_in_run++;
    end
    busy_prev = busy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic set_ops(input int r, input int a, input int b);
    a_in[r*WIDTH +: WIDTH] = WIDTH'(a);
    b_in[r*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  task automatic wait_gnt(output logic [N_REQ-1:0] g);
    g = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt != '0) begin
        g = gnt;
        break;
      end
    end
  endtask

  // Called in the gnt cycle; returns cycles until done and busy cycles seen.
  task automatic wait_done(output int cyc, output int bcyc, output logic [N_REQ-1:0] d);
    cyc  = 0;
    bcyc = busy ? 1 : 0;
    d    = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cyc++;
      if (done != '0) begin
        d = done;
        break;
      end
      if (busy) bcyc++;
    end
  endtask

  task automatic run_op(input int r, input int a, input int b, input int exp_p, input string tag);
    logic [N_REQ-1:0] g;
    logic [N_REQ-1:0] d;
    int cyc;
    int bcyc;
    @(negedge clk);
    set_ops(r, a, b);
    req[r] = 1'b1;
    wait_gnt(g);
    req[r] = 1'b0;
    check({tag, "_gnt"}, 32'(g), 32'(1) << r);
    check({tag, "_owner"}, 32'(owner), 32'(r));
    check({tag, "_busy_at_gnt"}, 32'(busy), 32'd1);
    wait_done(cyc, bcyc, d);
    check({tag, "_latency"}, 32'(cyc), 32'(WIDTH));
    check({tag, "_done"}, 32'(d), 32'(1) << r);
    check({tag, "_product"}, 32'(product), 32'(exp_p));
    check({tag, "_busy_cycles"}, 32'(bcyc), 32'(WIDTH));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [N_REQ-1:0] g;
    logic [N_REQ-1:0] d;
    int cyc;
    int bcyc;
    int done_seen;
    n_cmp = 0; n_err = 0; gnt_multi = 0; gnt_in_run = 0; busy_prev = 1'b0;
    rst = 1'b1; req = '0; a_in = '0; b_in = '0;
    repeat (3) @(negedge clk);
    check("reset_gnt", 32'(gnt), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    check("reset_owner", 32'(owner), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;

    // 1: max operands
    run_op(0, 63, 63, 3969, "max");
    repeat (3) @(negedge clk);
    check("product_hold", 32'(product), 32'd3969);

    // 2: zero operands, same latency
    run_op(0, 45, 0, 0, "zero_b");
    run_op(0, 37, 37, 1369, "refill");
    run_op(0, 0, 37, 0, "zero_a");

    // 3: simultaneous requests after reset
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_ops(0, 3, 5);
    set_ops(1, 7, 9);
    req = 2'b11;
    wait_gnt(g);
    req[0] = 1'b0;
    check("simul_first_gnt", 32'(g), 32'd1);
    wait_done(cyc, bcyc, d);
    check("simul_done0", 32'(d), 32'd1);
    check("simul_product0", 32'(product), 32'd15);
    check("simul_latency0", 32'(cyc), 32'(WIDTH));
    @(negedge clk);
    check("simul_second_gnt", 32'(gnt), 32'd2);
    check("simul_owner1", 32'(owner), 32'd1);
    req[1] = 1'b0;
    wait_done(cyc, bcyc, d);
    check("simul_done1", 32'(d), 32'd2);
    check("simul_product1", 32'(product), 32'd63);

    // 4: both held for four operations, grants alternate
    @(negedge clk);
    set_ops(0, 2, 3);
    set_ops(1, 5, 4);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_gnt(g);
      if (k == 3) req = '0;
      check($sformatf("alt%0d_gnt", k), 32'(g), 32'(1) << (k % 2));
      check($sformatf("alt%0d_owner", k), 32'(owner), 32'(k % 2));
      wait_done(cyc, bcyc, d);
      check($sformatf("alt%0d_done", k), 32'(d), 32'(1) << (k % 2));
      check($sformatf("alt%0d_product", k), 32'(product), (k % 2 == 0) ? 32'd6 : 32'd20);
    end

    // 5: reset in the middle of a run abandons it
    @(negedge clk);
    set_ops(1, 12, 10);
    req[1] = 1'b1;
    wait_gnt(g);
    req[1] = 1'b0;
    check("abort_gnt", 32'(g), 32'd2);
    repeat (3) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_product", 32'(product), 32'd0);
    check("abort_owner", 32'(owner), 32'd0);
    check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done != '0) done_seen++;
    end
    check("abort_no_done", 32'(done_seen), 32'd0);
    run_op(1, 12, 10, 120, "reissue");

    // 6: operands change the cycle after grant
    @(negedge clk);
    set_ops(0, 20, 3);
    req[0] = 1'b1;
    wait_gnt(g);
    req[0] = 1'b0;
    check("iso_gnt", 32'(g), 32'd1);
    @(negedge clk);
    set_ops(0, 63, 63);
    wait_done(cyc, bcyc, d);
    check("iso_latency", 32'(cyc), 32'(WIDTH - 1));
    check("iso_done", 32'(d), 32'd1);
    check("iso_product", 32'(product), 32'd60);

    check("gnt_onehot", 32'(gnt_multi), 32'd0);
    check("gnt_not_in_run", 32'(gnt_in_run), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
